// File: rtl/dec38_seq.sv
// ---------------------------------------------------------------------------
// dec38_seq
//   Sequential 3-to-8 decoder. 3-bit codes arrive over a valid/ready
//   handshake, are buffered in a small circular FIFO, and are replayed in
//   order as one-hot pulses on y. Each pulse lasts PULSE_LEN cycles and is
//   followed by a GAP_LEN-cycle gap where y is zero.
//
// Ports
//   clk       : clock, all state on rising edge
//   rst_n     : asynchronous active-low reset
//   in_valid  : in_code is valid this cycle
//   in_ready  : FIFO can accept a code this cycle (level != DEPTH)
//   in_code   : binary code 0..7
//   y         : one-hot decoded word, 8'h00 when idle or in gap
//   y_valid   : high exactly while y is non-zero
//   busy      : FSM not idle, or FIFO non-empty
//   level     : current FIFO occupancy
//   count     : number of codes popped, wraps modulo 2^CW
// ---------------------------------------------------------------------------
module dec38_seq #(
    parameter int DEPTH     = 4,
    parameter int PULSE_LEN = 2,
    parameter int GAP_LEN   = 1,
    parameter int CW        = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [2:0]               in_code,
    output logic [7:0]               y,
    output logic                     y_valid,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   level,
    output logic [CW-1:0]            count
);

    localparam int AW   = $clog2(DEPTH);
    localparam int LW   = AW + 1;
    localparam int TMAX = (PULSE_LEN > GAP_LEN) ? PULSE_LEN : GAP_LEN;
    // tmr only ever holds values up to TMAX-1
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        GAP   = 2'd2
    } state_t;

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    state_t          state_reg;
    logic [TW-1:0]   tmr_reg;
    logic [7:0]      y_reg;
    logic            y_valid_reg;
    logic [CW-1:0]   count_reg;

    logic [2:0]      mem [DEPTH];
    logic [AW-1:0]   wr_ptr_reg;
    logic [AW-1:0]   rd_ptr_reg;
    logic [LW-1:0]   level_reg;

    // -----------------------------------------------------------------------
    // Handshake and pop decision, all from registered state
    // -----------------------------------------------------------------------
    logic            push;
    logic            pop;
    logic            fifo_nonempty;
    logic [2:0]      head_code;
    logic [7:0]      head_onehot;

    assign fifo_nonempty = (level_reg != '0);
    // Full FIFO refuses input even when it pops this edge.
    assign in_ready      = (level_reg != LW'(DEPTH));
    assign push          = in_valid && in_ready;
    // Pop from IDLE, or straight out of the last GAP cycle with no IDLE cycle.
    assign pop           = fifo_nonempty &&
                           ((state_reg == IDLE) ||
                            ((state_reg == GAP) && (tmr_reg == '0)));

    // The head must be visible in the same cycle the pop decision is made,
    // so the FIFO storage is read asynchronously (small distributed array).
    assign head_code = mem[rd_ptr_reg];

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_decode
            assign head_onehot[gi] = (head_code == 3'(gi));
        end
    endgenerate

    // -----------------------------------------------------------------------
    // FIFO storage: no reset needed, occupancy is tracked by level_reg.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= in_code;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            case ({push, pop})
                2'b10:   level_reg <= level_reg + LW'(1);
                2'b01:   level_reg <= level_reg - LW'(1);
                default: level_reg <= level_reg;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Output FSM. One down-counter times both the pulse and the gap.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            tmr_reg     <= '0;
            y_reg       <= '0;
            y_valid_reg <= 1'b0;
            count_reg   <= '0;
        end else begin
            if (pop) begin
                count_reg <= count_reg + CW'(1);
            end

            case (state_reg)
                IDLE: begin
                    if (pop) begin
                        y_reg       <= head_onehot;
                        y_valid_reg <= 1'b1;
                        tmr_reg     <= TW'(PULSE_LEN - 1);
                        state_reg   <= DRIVE;
                    end
                end

                DRIVE: begin
                    if (tmr_reg == '0) begin
                        y_reg       <= '0;
                        y_valid_reg <= 1'b0;
                        tmr_reg     <= TW'(GAP_LEN - 1);
                        state_reg   <= GAP;
                    end else begin
                        tmr_reg <= tmr_reg - TW'(1);
                    end
                end

                GAP: begin
                    if (tmr_reg == '0) begin
                        if (pop) begin
                            y_reg       <= head_onehot;
                            y_valid_reg <= 1'b1;
                            tmr_reg     <= TW'(PULSE_LEN - 1);
                            state_reg   <= DRIVE;
                        end else begin
                            state_reg <= IDLE;
                        end
                    end else begin
                        tmr_reg <= tmr_reg - TW'(1);
                    end
                end

                default: begin
                    state_reg   <= IDLE;
                    y_reg       <= '0;
                    y_valid_reg <= 1'b0;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign y       = y_reg;
    assign y_valid = y_valid_reg;
    assign level   = level_reg;
    assign count   = count_reg;
    assign busy    = (state_reg != IDLE) || fifo_nonempty;

endmodule

// File: tb/tb_dec38_seq.sv
// ---------------------------------------------------------------------------
// tb_dec38_seq
//   Directed and randomized bench for dec38_seq. The reference model is a
//   code queue plus a time-slot schedule: a code popped at edge p is shown
//   on y after edges p .. p+PULSE_LEN-1, and the next pop may happen no
//   earlier than edge p+PULSE_LEN+GAP_LEN.
// ---------------------------------------------------------------------------
module tb_dec38_seq;

    localparam int DEPTH     = 4;
    localparam int PULSE_LEN = 2;
    localparam int GAP_LEN   = 1;
    localparam int CW        = 8;
    localparam int LW        = $clog2(DEPTH) + 1;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [2:0]     in_code = 3'd0;
    logic [7:0]     y;
    logic           y_valid;
    logic           busy;
    logic [LW-1:0]  level;
    logic [CW-1:0]  count;

    dec38_seq #(
        .DEPTH    (DEPTH),
        .PULSE_LEN(PULSE_LEN),
        .GAP_LEN  (GAP_LEN),
        .CW       (CW)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_code (in_code),
        .y       (y),
        .y_valid (y_valid),
        .busy    (busy),
        .level   (level),
        .count   (count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int q[$];
    int edge_n    = 0;
    int next_pop  = 0;
    int pulse_end = 0;
    int cur_code  = 0;
    int m_count   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock edge: update the model with the inputs presented at
    // this edge, then compare every output on the following falling edge.
    task automatic step(output bit acc_o);
        int pre;
        int e;
        int exp_y;
        bit do_pop;
        pre    = q.size();
        e      = edge_n;
        acc_o  = 1'b0;
        if (rst_n) begin
            acc_o  = in_valid && (pre != DEPTH);
            do_pop = (e >= next_pop) && (pre != 0);
            if (do_pop) begin
                cur_code  = q.pop_front();
                pulse_end = e + PULSE_LEN;
                next_pop  = e + PULSE_LEN + GAP_LEN;
                m_count   = (m_count + 1) % (1 << CW);
            end
            if (acc_o) q.push_back(int'(in_code));
        end else begin
            q.delete();
            next_pop  = 0;
            pulse_end = 0;
            m_count   = 0;
        end
        @(posedge clk);
        @(negedge clk);
        edge_n++;
        exp_y = (e < pulse_end) ? (1 << cur_code) : 0;
        check("y",        32'(y),        32'(exp_y));
        check("y_valid",  32'(y_valid),  32'(exp_y != 0));
        check("level",    32'(level),    32'(q.size()));
        check("in_ready", 32'(in_ready), 32'(q.size() != DEPTH));
        check("count",    32'(count),    32'(m_count));
        check("busy",     32'(busy),     32'((e < next_pop) || (q.size() != 0)));
    endtask

    // Present a code and hold in_valid until the model says it was taken.
    task automatic push_code(input logic [2:0] c);
        bit acc;
        int tries;
        in_code  = c;
        in_valid = 1'b1;
        tries    = 0;
        acc      = 1'b0;
        while (!acc && tries < 50) begin
            step(acc);
            tries++;
        end
        if (!acc) check("accept_timeout", 32'(0), 32'(1));
    endtask

    task automatic idle_steps(input int n);
        bit acc;
        in_valid = 1'b0;
        for (int i = 0; i < n; i++) step(acc);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc;

        // 1. Reset held with a valid code offered: nothing accepted.
        rst_n    = 1'b0;
        in_valid = 1'b1;
        in_code  = 3'd5;
        step(acc);
        step(acc);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        idle_steps(2);

        // 2. Single code from idle.
        push_code(3'd5);
        idle_steps(6);
        check("single_count", 32'(count), 32'(1));
        check("single_busy",  32'(busy),  32'(0));

        // 3. Sweep 0..7 back to back, in_valid held high.
        for (int c = 0; c < 8; c++) push_code(3'(c));
        idle_steps(30);
        check("sweep_count", 32'(count), 32'(9));

        // 4. Back-pressure: fill the FIFO, then offer code 7 until taken.
        push_code(3'd1);
        push_code(3'd2);
        push_code(3'd3);
        push_code(3'd4);
        push_code(3'd6);
        push_code(3'd7);
        idle_steps(30);

        // 5. Asynchronous reset during the first pulse of three queued codes.
        push_code(3'd2);
        push_code(3'd3);
        push_code(3'd4);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("async_y",       32'(y),       32'(0));
        check("async_y_valid", 32'(y_valid), 32'(0));
        check("async_level",   32'(level),   32'(0));
        check("async_count",   32'(count),   32'(0));
        step(acc);
        rst_n = 1'b1;
        idle_steps(10);

        // 6. Counter and pointer wrap: 257 codes.
        for (int i = 0; i < 257; i++) push_code(3'($urandom_range(0, 7)));
        idle_steps(30);
        check("wrap_count", 32'(count), 32'(1));

        // 7. Random traffic.
        for (int i = 0; i < 400; i++) begin
            in_valid = ($urandom_range(0, 99) < 55);
            in_code  = 3'($urandom_range(0, 7));
            step(acc);
        end
        idle_steps(30);
        check("final_busy", 32'(busy), 32'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dec38_seq.md
Name: dec38_seq

Overview:
- Sequential 3-to-8 decoder: the return path for 3-bit codes produced by the 8:3 encoder.
- Accepts 3-bit codes through a valid/ready handshake and buffers them in a small FIFO.
- Drives each code in order as a one-hot 8-bit output pulse of programmable length, followed by a programmable idle gap.
- Sits between a code source (encoder or control logic) and one-hot consumers such as select lines or LEDs.

Parameters:
DEPTH, 4, FIFO entries; power of two, >= 2
PULSE_LEN, 2, cycles each one-hot word is held on y; >= 1
GAP_LEN, 1, cycles y is held at zero between words; >= 1
CW, 8, width of the decoded-word counter

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  in_code is valid this cycle
in_ready  output  1  FIFO can accept a code this cycle
in_code  input  3  binary code 0..7
y  output  8  one-hot decoded word; 8'h00 when idle or in gap
y_valid  output  1  high exactly while y is non-zero
busy  output  1  FSM not IDLE, or FIFO non-empty
level  output  $clog2(DEPTH)+1  current FIFO occupancy
count  output  CW  number of codes popped from the FIFO; wraps modulo 2^CW

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: y=0, y_valid=0, level=0, count=0, busy=0, in_ready=1, FSM=IDLE, FIFO pointers=0.
- Reset mid-operation: asserting rst_n low during DRIVE or GAP clears all state immediately. Buffered codes are discarded.
- Handshake:
  - A code is accepted on a rising edge where in_valid && in_ready.
  - in_ready = (level != DEPTH). It is derived from registered state only and does not depend on a same-cycle pop.
  - A full FIFO refuses input even in a cycle where it pops.
- FIFO:
  - Circular buffer; pointers wrap modulo DEPTH.
  - Push and pop on the same edge leave level unchanged.
  - Order is strictly preserved.
- FSM states: IDLE, DRIVE, GAP. A single down-counter tmr times both DRIVE and GAP.
  - IDLE: if level != 0, pop the head, load y = 8'b1 << code, set y_valid=1, tmr=PULSE_LEN-1, go to DRIVE. Otherwise stay.
  - DRIVE: hold y. When tmr==0: y=0, y_valid=0, tmr=GAP_LEN-1, go to GAP. Otherwise decrement tmr.
  - GAP:
    - When tmr==0 and level != 0: pop and go directly to DRIVE, loading as in IDLE. There is no extra IDLE cycle.
    - When tmr==0 and level == 0: go to IDLE.
    - Otherwise decrement tmr.
- count increments by 1 on every pop and wraps from 2^CW-1 to 0.
- Latency and throughput:
  - Accept at edge E with the FIFO empty and the FSM in IDLE: y becomes valid after edge E+1.
  - Steady-state period is PULSE_LEN+GAP_LEN cycles per code.
- Decode rule: y is always a single set bit for codes 0..7. Every 3-bit value is legal; there is no error case.
- busy falls only after GAP completes with the FIFO empty.

Test Plan:
1. Reset: hold rst_n=0 with in_valid=1 and in_code=3'd5 -> y=8'h00, y_valid=0, in_ready=1, level=0, count=0; no accept occurs.
2. Single code: push in_code=5 once from idle (PULSE_LEN=2, GAP_LEN=1) -> y=8'h20 for exactly 2 cycles starting one edge after the accept, then y=8'h00 for 1 cycle, then IDLE, busy=0, count=1.
3. Sweep: push codes 0..7 with in_valid held high -> y sequence 01,02,04,08,10,20,40,80, each held 2 cycles with a 1-cycle zero gap and no IDLE cycles between words; in_ready drops whenever level=4; no code lost or reordered; count=8.
4. Back-pressure: fill the FIFO to level=4 while a word is in DRIVE, hold in_valid=1 with in_code=7 -> in_ready=0 and level stays 4 until a pop; code 7 is accepted on the first edge after level falls to 3.
5. Reset mid-DRIVE: 3 codes queued, pulse rst_n low during the first pulse -> y=0 asynchronously; level=0 and count=0 after release; no further pulses appear.
6. Wrap: push 257 codes (CW=8) -> count reads 0 after the 256th pop and 1 after the 257th; FIFO pointers wrap with data intact.
